rram_ctrl_verify: RTL and testbench

- Parametrised successor to the RRAM control unit.
- Decodes the two-phase NAND-style command/address interface (CE, CLE, ALE) and sequences FORMING, WRITE and READ operations on the write/read and decoder blocks.
- Pulse counting is done internally, replacing the external cache/forming/write count flags, with configurable pulse lengths.
- Adds a write/form-verify retry loop with pass/fail status.

---
 rtl/rram_ctrl_pkg.sv | 46 ++++
 rtl/rram_pulse_timer.sv | 25 ++
 rtl/rram_ctrl_verify.sv | 158 +++++++++++++++
 tb/tb_rram_ctrl_verify.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rram_ctrl_pkg.sv
// Shared command codes, FSM state and status encodings for the RRAM controller.
package rram_ctrl_pkg;

  localparam logic [3:0] CMD_READ1  = 4'b0001;
  localparam logic [3:0] CMD_WRITE1 = 4'b0100;
  localparam logic [3:0] CMD_FORM1  = 4'b0110;
  localparam logic [3:0] CMD_READ2  = 4'b0011;
  localparam logic [3:0] CMD_WRITE2 = 4'b0010;
  localparam logic [3:0] CMD_FORM2  = 4'b0111;
  localparam logic [3:0] CMD_ABORT  = 4'b1111;

  typedef enum logic [3:0] {
    IDLE, ADDR, CONF, CACHE, WRITE, FORM, VERIFY, READ, DONE
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FORM} op_t;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00, ST_PASS = 2'b01, ST_FAIL = 2'b10, ST_CMD_ERR = 2'b11
  } status_t;

  function automatic logic is_array(input state_t s);
    return (s == CACHE) || (s == WRITE) || (s == FORM) || (s == VERIFY) || (s == READ);
  endfunction

  function automatic logic is_first(input logic [3:0] cmd);
    return (cmd == CMD_READ1) || (cmd == CMD_WRITE1) || (cmd == CMD_FORM1);
  endfunction

  function automatic op_t op_of(input logic [3:0] cmd);
    case (cmd)
      CMD_WRITE1: return OP_WRITE;
      CMD_FORM1:  return OP_FORM;
      default:    return OP_READ;
    endcase
  endfunction

  function automatic logic [3:0] confirm_code(input op_t op);
    case (op)
      OP_WRITE: return CMD_WRITE2;
      OP_FORM:  return CMD_FORM2;
      default:  return CMD_READ2;
    endcase
  endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module rram_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/rram_ctrl_verify.sv
// RRAM control unit: NAND-style command decode, FORM/WRITE/READ sequencing with
// an internal pulse timer and a verify/retry loop reporting PASS/FAIL status.
module rram_ctrl_verify
  import rram_ctrl_pkg::*;
#(
  parameter int CACHE_CYC = 4,
  parameter int WRITE_CYC = 8,
  parameter int FORM_CYC  = 16,
  parameter int READ_CYC  = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE,
  input  logic       CLE,
  input  logic       ALE,
  input  logic [3:0] command,
  input  logic       address_ready,
  input  logic       verify_pass,
  output logic       we_writeread,
  output logic       re_writeread,
  output logic       forming_writeread,
  output logic       WE_L,
  output logic       RE_L,
  output logic       en_decoder,
  output logic       RB,
  output logic [1:0] status,
  output logic [3:0] retry_cnt
);

  localparam int TW = (FORM_CYC > 1) ? $clog2(FORM_CYC) : 1;
  localparam logic [TW-1:0] CACHE_LD = TW'(CACHE_CYC - 1);
  localparam logic [TW-1:0] WRITE_LD = TW'(WRITE_CYC - 1);
  localparam logic [TW-1:0] FORM_LD  = TW'(FORM_CYC - 1);
  localparam logic [TW-1:0] READ_LD  = TW'(READ_CYC - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  state_t        state;
  op_t           op;
  status_t       status_q;
  logic [3:0]    retry_q;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  wire cmd_strobe = CLE & ~CE;
  wire abort      = cmd_strobe && (command == CMD_ABORT);

  // Timer is held loaded with the length of whichever timed state comes next,
  // and reloaded on the last cycle of a timed state, so each state lasts N cycles.
  always_comb begin
    tmr_load  = 1'b1;
    tmr_value = '0;
    case (state)
      CONF:        tmr_value = (op == OP_WRITE) ? CACHE_LD : (op == OP_FORM) ? FORM_LD : READ_LD;
      CACHE:       begin tmr_load = tmr_done; tmr_value = WRITE_LD; end
      WRITE, FORM: begin tmr_load = tmr_done; tmr_value = READ_LD; end
      VERIFY:      begin tmr_load = tmr_done; tmr_value = (op == OP_FORM) ? FORM_LD : WRITE_LD; end
      READ:        tmr_load = tmr_done;
      default:     ;
    endcase
  end

  rram_pulse_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= OP_READ;
      status_q <= ST_NONE;
      retry_q  <= '0;
    end else if (abort) begin
      state <= IDLE;
      if (is_array(state)) status_q <= ST_FAIL;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cmd_strobe && is_first(command)) begin
            op    <= op_of(command);
            state <= ADDR;
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          if (CE) state <= IDLE;
          else if (ALE && address_ready) state <= CONF;
        end
        CONF: begin
          if (CE) begin
            state <= IDLE;
          end else if (CLE) begin
            if (command == confirm_code(op)) begin
              retry_q  <= '0;
              status_q <= ST_NONE;
              state    <= (op == OP_WRITE) ? CACHE : (op == OP_FORM) ? FORM : READ;
            end else begin
              status_q <= ST_CMD_ERR;
              state    <= IDLE;
            end
          end
        end
        CACHE:       if (tmr_done) state <= WRITE;
        WRITE, FORM: if (tmr_done) state <= VERIFY;
        VERIFY: begin
          if (tmr_done) begin
            if (verify_pass) begin
              status_q <= ST_PASS;
              state    <= DONE;
            end else if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + 1'b1;
              state   <= (op == OP_FORM) ? FORM : WRITE;
            end else begin
              status_q <= ST_FAIL;
              state    <= DONE;
            end
          end
        end
        READ: begin
          if (tmr_done) begin
            status_q <= ST_PASS;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    we_writeread      = 1'b0;
    re_writeread      = 1'b0;
    forming_writeread = 1'b0;
    WE_L              = 1'b1;
    RE_L              = 1'b1;
    en_decoder        = 1'b0;
    RB                = 1'b1;
    case (state)
      CONF:   en_decoder = 1'b1;
      CACHE:  begin WE_L = 1'b0; en_decoder = 1'b1; RB = 1'b0; end
      WRITE:  begin we_writeread = 1'b1; en_decoder = 1'b1; RB = 1'b0; end
      FORM:   begin forming_writeread = 1'b1; en_decoder = 1'b1; RB = 1'b0; end
      VERIFY: begin re_writeread = 1'b1; en_decoder = 1'b1; RB = 1'b0; end
      READ:   begin re_writeread = 1'b1; RE_L = 1'b0; en_decoder = 1'b1; RB = 1'b0; end
      default: ;
    endcase
  end

  assign status    = status_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_rram_ctrl_verify.sv
// Scoreboard bench: driver pushes per-operation expectations, monitor tallies pulse activity and compares.
module tb_rram_ctrl_verify;

  localparam int CACHE_CYC = 4;
  localparam int WRITE_CYC = 8;
  localparam int FORM_CYC  = 16;
  localparam int READ_CYC  = 4;
  localparam int MAX_RETRY = 3;

  localparam int K_READ = 0, K_WRITE = 1, K_FORM = 2, K_BADCONF = 3;

  logic       clk = 1'b0;
  logic       rst, CE, CLE, ALE, address_ready, verify_pass;
  logic [3:0] command;
  logic       we_writeread, re_writeread, forming_writeread, WE_L, RE_L, en_decoder, RB;
  logic [1:0] status;
  logic [3:0] retry_cnt;

  rram_ctrl_verify #(
    .CACHE_CYC(CACHE_CYC), .WRITE_CYC(WRITE_CYC), .FORM_CYC(FORM_CYC),
    .READ_CYC(READ_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .CE(CE), .CLE(CLE), .ALE(ALE), .command(command),
    .address_ready(address_ready), .verify_pass(verify_pass),
    .we_writeread(we_writeread), .re_writeread(re_writeread),
    .forming_writeread(forming_writeread), .WE_L(WE_L), .RE_L(RE_L),
    .en_decoder(en_decoder), .RB(RB), .status(status), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int busy, wel, we, fm, re, rel, pulses, status, retry;
    bit chk_counts;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  logic txn_end = 1'b0;
  int   m_retry = 0;

  // Verify responder: the first fail_k verify windows of an operation report fail.
  int   fail_k = 0;
  int   vcount = 0;
  logic re_prev = 1'b0;
  assign verify_pass = (vcount >= fail_k);

  always @(negedge clk) begin
    if (RB) vcount = 0;
    else if (re_prev && !re_writeread) vcount = vcount + 1;
    re_prev = re_writeread;
  end

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  int   c_busy = 0, c_wel = 0, c_we = 0, c_fm = 0, c_re = 0, c_rel = 0, c_pul = 0;
  logic pul_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!RB) c_busy++;
    if (!WE_L) c_wel++;
    if (we_writeread) c_we++;
    if (forming_writeread) c_fm++;
    if (re_writeread) c_re++;
    if (!RE_L) c_rel++;
    if ((we_writeread || forming_writeread) && !pul_prev) c_pul++;
    pul_prev = we_writeread || forming_writeread;
    if (txn_end) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.chk_counts) begin
          chk("busy_cycles", c_busy, e.busy);
          chk("we_l_low_cycles", c_wel, e.wel);
          chk("write_cycles", c_we, e.we);
          chk("form_cycles", c_fm, e.fm);
          chk("re_cycles", c_re, e.re);
          chk("re_l_low_cycles", c_rel, e.rel);
          chk("pulse_count", c_pul, e.pulses);
        end
        chk("status", int'(status), e.status);
        chk("retry_cnt", int'(retry_cnt), e.retry);
        chk("idle_outputs",
            int'({we_writeread, re_writeread, forming_writeread, WE_L, RE_L, en_decoder, RB}),
            int'(7'b0001101));
      end
      c_busy = 0; c_wel = 0; c_we = 0; c_fm = 0; c_re = 0; c_rel = 0; c_pul = 0;
    end
  end

  // Reference model: whole-operation totals from the command rules.
  function automatic exp_t model(input int kind, input int k, input int prev_retry);
    exp_t e;
    int attempts;
    int pulse_len;
    e = '{default: 0};
    e.chk_counts = 1'b1;
    attempts = (k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1;
    case (kind)
      K_READ: begin
        e.busy = READ_CYC; e.re = READ_CYC; e.rel = READ_CYC;
        e.status = 1; e.retry = 0;
      end
      K_WRITE, K_FORM: begin
        pulse_len = (kind == K_WRITE) ? WRITE_CYC : FORM_CYC;
        e.busy    = attempts * (pulse_len + READ_CYC) + ((kind == K_WRITE) ? CACHE_CYC : 0);
        e.wel     = (kind == K_WRITE) ? CACHE_CYC : 0;
        e.we      = (kind == K_WRITE) ? attempts * WRITE_CYC : 0;
        e.fm      = (kind == K_FORM) ? attempts * FORM_CYC : 0;
        e.re      = attempts * READ_CYC;
        e.pulses  = attempts;
        e.status  = (k <= MAX_RETRY) ? 1 : 2;
        e.retry   = attempts - 1;
      end
      default: begin
        e.status = 3; e.retry = prev_retry;
      end
    endcase
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c1, input logic [3:0] c2);
    CE = 1'b0; CLE = 1'b1; command = c1;
    step();
    CLE = 1'b0; command = 4'h0; ALE = 1'b1; address_ready = 1'b1;
    step();
    ALE = 1'b0; address_ready = 1'b0; CLE = 1'b1; command = c2;
    step();
    CLE = 1'b0; command = 4'h0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!RB && n < 1000) begin
      step();
      n++;
    end
    if (!RB) chk("ready_timeout", 0, 1);
  endtask

  task automatic end_txn();
    txn_end = 1'b1;
    step();
    txn_end = 1'b0;
  endtask

  task automatic run_op(input int kind, input int k);
    exp_t e;
    logic [3:0] c1, c2, good;
    e = model(kind, k, m_retry);
    exp_q.push_back(e);
    m_retry = e.retry;
    fail_k  = k;
    case (kind)
      K_READ:  begin c1 = 4'b0001; c2 = 4'b0011; end
      K_WRITE: begin c1 = 4'b0100; c2 = 4'b0010; end
      K_FORM:  begin c1 = 4'b0110; c2 = 4'b0111; end
      default: begin
        c1   = 4'b0100;
        good = 4'b0010;
        c2   = 4'($urandom_range(0, 14));
        if (c2 == good) c2 = 4'b0011;
      end
    endcase
    issue(c1, c2);
    wait_ready();
    end_txn();
  endtask

  task automatic wait_we_cycles(input int target, input bit form);
    int n = 0;
    int guard = 0;
    while (n < target && guard < 1000) begin
      @(negedge clk);
      if (form ? forming_writeread : we_writeread) n++;
      guard++;
    end
    if (n < target) chk("pulse_timeout", n, target);
  endtask

  initial begin
    exp_t e;
    int kind;
    rst = 1'b1; CE = 1'b1; CLE = 1'b0; ALE = 1'b0; address_ready = 1'b0; command = 4'h0;
    repeat (3) step();
    e = '{default: 0};
    e.chk_counts = 1'b1;
    exp_q.push_back(e);
    end_txn();
    rst = 1'b0;
    step();

    run_op(K_WRITE, 0);
    run_op(K_WRITE, 2);
    run_op(K_FORM, 99);
    run_op(K_READ, 0);
    run_op(K_BADCONF, 0);

    // ABORT on the third cycle of the first write pulse.
    e = '{default: 0};
    e.chk_counts = 1'b1;
    e.busy = CACHE_CYC + 3; e.wel = CACHE_CYC; e.we = 3; e.pulses = 1;
    e.status = 2; e.retry = 0;
    exp_q.push_back(e);
    m_retry = 0;
    fail_k  = 0;
    issue(4'b0100, 4'b0010);
    wait_we_cycles(3, 1'b0);
    CLE = 1'b1; command = 4'b1111;
    step();
    CLE = 1'b0; command = 4'h0;
    end_txn();

    // Reset pulse in the middle of a forming pulse.
    e = '{default: 0};
    e.chk_counts = 1'b0;
    exp_q.push_back(e);
    m_retry = 0;
    fail_k  = 0;
    issue(4'b0110, 4'b0111);
    wait_we_cycles(5, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    end_txn();
    run_op(K_READ, 0);

    for (int i = 0; i < 14; i++) begin
      CE = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step();
      kind = $urandom_range(0, 3);
      run_op(kind, $urandom_range(0, 5));
    end

    repeat (2) step();
    if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
